fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Drain side of a BRAM-backed FIFO. The block pops DATAW-bit words from the FIFO read port and serialises each word as consecutive UART 8N1 frames, byte 0 (LSB byte) first. It sits between the core's output FIFO and the board TX pin, and is the transmit counterpart of the host-to-core receive path.

Parameters:
DATAW, 32, FIFO word width; must be a multiple of 8 (elaboration error otherwise)
CLK_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2
BYTES, DATAW/8, bytes per word (derived; do not override)

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
fifo_empty  input  1  FIFO empty flag (registered at the FIFO)
fifo_dout  input  DATAW  FIFO head word; valid when fifo_empty has been low for at least 1 full cycle
fifo_r_en  output  1  one-cycle pop strobe to the FIFO
txd  output  1  UART serial out, idle high
busy  output  1  high from word fetch until the last stop bit ends
words_sent  output  16  count of fully transmitted words, wraps mod 2^16

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, txd=1, fifo_r_en=0, busy=0, words_sent=0, all counters 0. Asserting reset mid-frame aborts immediately: txd goes high with no partial stop bit. The popped word is lost.
- States: IDLE, SETTLE, START, DATA, STOP.
- IDLE: txd=1, busy=0. If fifo_empty==0, go to SETTLE.
- SETTLE (1 cycle): re-check fifo_empty.
  - If 1, go back to IDLE with no pop.
  - If 0: fifo_r_en=1 for this cycle only, latch fifo_dout into shift register sh, byte_idx=0, baud_cnt=0, go to START.
  - This guarantees fifo_dout is sampled at least 1 cycle after empty fell, which covers the 1-cycle BRAM read latency.
- fifo_r_en is registered-free combinational from state only, and is high only in SETTLE with ~fifo_empty. It must never be high while fifo_empty=1.
- START: txd=0 for exactly CLK_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: txd=sh[byte_idx*8+bit_idx] for CLK_PER_BIT cycles per bit, LSB first. After bit_idx=7, go to STOP.
- STOP: txd=1 for CLK_PER_BIT cycles. At the end of the stop bit:
  - If byte_idx<BYTES-1: byte_idx+1, go to START (no inter-byte gap).
  - Otherwise: words_sent+1, go to IDLE.
- busy=1 in START, DATA and STOP, and during the SETTLE cycle that pops.
- Frame length is 10*CLK_PER_BIT cycles. A word takes BYTES*10*CLK_PER_BIT cycles.
- Inter-word gap: txd high for exactly 2 extra cycles (IDLE + SETTLE) after the last stop bit when the FIFO is non-empty.
- Counter widths:
  - baud_cnt: $clog2(CLK_PER_BIT); counts 0..CLK_PER_BIT-1 and rolls at terminal count.
  - bit_idx: 3 bits.
  - byte_idx: max($clog2(BYTES),1) bits.
- The FIFO becoming empty or refilling while a word is in flight has no effect. The block samples fifo_empty only in IDLE and SETTLE.
- Exactly one fifo_r_en pulse per transmitted word. No pop ever occurs without a matching full word on txd, except when reset aborts the word.

Test Plan:
- CLK_PER_BIT=4, DATAW=32. Preload 0x44332211, release empty:
  - fifo_r_en pulses once, 2 cycles after empty falls.
  - txd carries frames 0x11, 0x22, 0x33, 0x44, each 40 cycles low-start / LSB-first / high-stop, 160 cycles total.
  - words_sent=1, busy falls on the cycle after the last stop.
- Three words back-to-back (0xDEADBEEF, 0x00000000, 0xFFFFFFFF):
  - Exactly 3 pops.
  - Inter-word gap is exactly 2 high cycles.
  - The all-zero word shows 4 frames of 9 low bits each.
  - words_sent=3.
- Glitch: fifo_empty low for 1 cycle only, then high. Required: no fifo_r_en, txd stays 1, return to IDLE.
- Reset mid-DATA (rstn low in the middle of byte 2). Required:
  - txd=1 and fifo_r_en=0 asynchronously, words_sent=0.
  - After release with the FIFO non-empty, the next word is transmitted intact from byte 0.
- Counter wrap: force 65536 single-byte words (DATAW=8, CLK_PER_BIT=2). Required: words_sent wraps to 0, and one pop per word.
- Assertions throughout:
  - fifo_r_en is never high while fifo_empty=1.
  - txd is never low in IDLE.
  - Each bit period is exactly CLK_PER_BIT cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Drains a BRAM-backed FIFO onto a UART 8N1 line: each popped DATAW-bit word
// leaves as BYTES back-to-back frames, least significant byte first.
module fifo_uart_tx #(
    parameter int DATAW       = 32,
    parameter int CLK_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fifo_empty,
    input  logic [DATAW-1:0] fifo_dout,
    output logic             fifo_r_en,
    output logic             txd,
    output logic             busy,
    output logic [15:0]      words_sent
);

    localparam int BYTES  = DATAW / 8;
    localparam int BAUD_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    if (DATAW % 8 != 0 || DATAW < 8) begin : g_bad_dataw
        $error("fifo_uart_tx: DATAW (%0d) must be a non-zero multiple of 8", DATAW);
    end
    if (CLK_PER_BIT < 2) begin : g_bad_clk_per_bit
        $error("fifo_uart_tx: CLK_PER_BIT (%0d) must be at least 2", CLK_PER_BIT);
    end

    logic [2:0]        state_q,      state_d;
    logic [DATAW-1:0]  sh_q,         sh_d;
    logic [BAUD_W-1:0] baud_cnt_q,   baud_cnt_d;
    logic [2:0]        bit_idx_q,    bit_idx_d;
    logic [BYTE_W-1:0] byte_idx_q,   byte_idx_d;
    logic [15:0]       words_sent_q, words_sent_d;

    logic bit_end;

    assign bit_end = (baud_cnt_q == BAUD_LAST);

    // The pop is only ever qualified by a second look at fifo_empty, so it can
    // never fire against an empty FIFO.
    assign fifo_r_en  = (state_q == ST_SETTLE) && !fifo_empty;
    assign busy       = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_STOP)  || fifo_r_en;
    assign words_sent = words_sent_q;

    always_comb begin
        txd = 1'b1;
        if (state_q == ST_START) begin
            txd = 1'b0;
        end else if (state_q == ST_DATA) begin
            txd = sh_q[0];
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        sh_d         = sh_q;
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        words_sent_d = words_sent_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end else begin
                    sh_d       = fifo_dout;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    baud_cnt_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
                if (bit_end) begin
                    // Shifting right walks straight through the word, so the
                    // next byte's LSB is already in bit 0 after eight shifts.
                    sh_d = {1'b0, sh_q[DATAW-1:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
                if (bit_end) begin
                    if (byte_idx_q == BYTE_LAST) begin
                        words_sent_d = words_sent_q + 16'd1;
                        state_d      = ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + BYTE_W'(1);
                        state_d    = ST_START;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            // NOTE: the shift register is reset even though it is only read
            // after a load, keeping txd free of X on the first frame in sim.
            sh_q         <= '0;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            words_sent_q <= words_sent_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model plus UART frame decoder feeding a byte
// scoreboard; a second 8-bit instance exercises the words_sent wrap.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 32;

    logic          clk        = 1'b0;
    logic          rstn       = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout  = '0;
    logic          fifo_r_en;
    logic          txd;
    logic          busy;
    logic [15:0]   words_sent;

    logic          s_empty = 1'b1;
    logic [7:0]    s_dout  = '0;
    logic          s_r_en;
    logic          s_txd;
    logic          s_busy;
    logic [15:0]   s_words;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pops     = 0;
    int s_pops   = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] head_q     = '0;
    logic          glitch_low = 1'b0;
    logic [7:0]    exp_q[$];
    int            gap_q[$];

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATAW(DW), .CLK_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_r_en  (fifo_r_en),
        .txd        (txd),
        .busy       (busy),
        .words_sent (words_sent)
    );

    fifo_uart_tx #(.DATAW(8), .CLK_PER_BIT(2)) u_small (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (s_empty),
        .fifo_dout  (s_dout),
        .fifo_r_en  (s_r_en),
        .txd        (s_txd),
        .busy       (s_busy),
        .words_sent (s_words)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic frame_done(input logic [9:0] fr, input logic bad);
        logic [7:0] e;
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        check("frame", {21'd0, bad, fr[9], fr[0], fr[8:1]}, {21'd0, 1'b0, 1'b1, 1'b0, e});
    endtask

    task automatic wait_done(input int limit, input string tag);
        bit done = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (!busy && fifo_q.size() == 0 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO with registered empty and a one-cycle-late head word, like a BRAM.
    always @(posedge clk) begin
        if (fifo_r_en) begin
            check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        fifo_empty <= (fifo_q.size() == 0) && !glitch_low;
        head_q     <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
        fifo_dout  <= head_q;
    end

    // UART decoder: every sample of a bit must agree, start low, stop high.
    bit         m_act = 1'b0;
    int         m_bit = 0;
    int         m_cnt = 0;
    int         m_gap = 0;
    logic       m_val = 1'b1;
    logic       m_bad = 1'b0;
    logic [9:0] m_sh  = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            m_act <= 1'b0;
            m_gap <= 0;
        end else if (!m_act) begin
            if (txd == 1'b0) begin
                m_act <= 1'b1;
                m_bit <= 0;
                m_cnt <= 1;
                m_val <= 1'b0;
                m_bad <= 1'b0;
                m_sh  <= '0;
                gap_q.push_back(m_gap);
            end else begin
                m_gap <= m_gap + 1;
            end
        end else begin
            if (m_cnt == 0) m_val <= txd;
            else if (txd !== m_val) m_bad <= 1'b1;
            if (m_cnt == CPB - 1) begin
                m_cnt <= 0;
                m_sh  <= {txd, m_sh[9:1]};
                if (m_bit == 9) begin
                    m_act <= 1'b0;
                    m_gap <= 0;
                    frame_done({txd, m_sh[9:1]}, m_bad || (txd !== m_val));
                end else begin
                    m_bit <= m_bit + 1;
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("ren_while_empty",   32'(fifo_r_en && fifo_empty), 32'd0);
        check("txd_low_when_idle", 32'(!busy && !txd),           32'd0);
        check("busy_on_pop",       32'(fifo_r_en && !busy),      32'd0);
        check("s_ren_while_empty", 32'(s_r_en && s_empty),       32'd0);
        if (fifo_r_en) pops   <= pops + 1;
        if (s_r_en)    s_pops <= s_pops + 1;
    end

    initial begin
        int          c1, c2, t0, t1, base_pops, base_ws;
        bit          ok, low_seen, busy_seen;
        logic [15:0] exp16;
        int          exp_gaps[11];
        exp_gaps = '{0, 0, 0, 2, 0, 0, 0, 2, 0, 0, 0};
        c1 = 0; c2 = 0; t0 = 0; t1 = 0;

        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd",        32'(txd),        32'd1);
        check("rst_r_en",       32'(fifo_r_en),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_words_sent", 32'(words_sent), 32'd0);
        check("rst_s_txd",      32'(s_txd),      32'd1);
        check("rst_s_words",    32'(s_words),    32'd0);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (3) @(posedge clk);

        // Single word: pop timing, frame contents, word length.
        #1 push_word(32'h44332211);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!fifo_empty) begin c1 = cyc; ok = 1'b1; break; end
        end
        check("empty_fall_seen", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (fifo_r_en) begin c2 = cyc; ok = 1'b1; break; end
        end
        check("pop_seen", 32'(ok), 32'd1);
        check("pop_edge_after_fall", 32'(c2 + 1 - c1), 32'd2);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!txd) begin t0 = cyc; ok = 1'b1; break; end
        end
        check("start_seen", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin t1 = cyc; ok = 1'b1; break; end
        end
        check("busy_fall_seen", 32'(ok), 32'd1);
        check("word_cycles", 32'(t1 - t0), 32'd160);
        check("ws_after_one", 32'(words_sent), 32'd1);
        check("pops_after_one", 32'(pops), 32'd1);
        check("sb_drained_one", 32'(exp_q.size()), 32'd0);

        // Three words back to back, including all-zero and all-one words.
        gap_q.delete();
        base_pops = pops;
        base_ws   = int'(words_sent);
        @(posedge clk);
        #1;
        push_word(32'hDEADBEEF);
        push_word(32'h00000000);
        push_word(32'hFFFFFFFF);
        wait_done(700, "three_words_done");
        check("pops_three",  32'(pops - base_pops), 32'd3);
        check("ws_three",    32'(words_sent), 32'(16'(base_ws + 3)));
        check("frame_count", 32'(gap_q.size()), 32'd12);
        for (int i = 1; i < gap_q.size() && i < 12; i++)
            check($sformatf("gap_%0d", i), 32'(gap_q[i]), 32'(exp_gaps[i-1]));

        // One-cycle empty glitch must not pop or disturb the line.
        base_pops = pops;
        base_ws   = int'(words_sent);
        @(posedge clk); #1 glitch_low = 1'b1;
        @(posedge clk); #1 glitch_low = 1'b0;
        low_seen  = 1'b0;
        busy_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!txd) low_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        check("glitch_pops",  32'(pops - base_pops), 32'd0);
        check("glitch_txd",   32'(low_seen),  32'd0);
        check("glitch_busy",  32'(busy_seen), 32'd0);
        check("glitch_ws",    32'(words_sent), 32'(base_ws));

        // Reset in the middle of byte 2; the popped word is lost.
        base_pops = pops;
        @(posedge clk); #1 push_word(32'hA5C30F96);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (fifo_r_en) begin ok = 1'b1; break; end
        end
        check("abort_pop_seen", 32'(ok), 32'd1);
        repeat (100) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("abort_txd",  32'(txd),        32'd1);
        check("abort_r_en", 32'(fifo_r_en),  32'd0);
        check("abort_busy", 32'(busy),       32'd0);
        check("abort_ws",   32'(words_sent), 32'd0);
        exp_q.delete();
        gap_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #1 push_word(32'h12345678);
        @(posedge clk); #1 rstn = 1'b1;
        wait_done(300, "after_abort_done");
        check("ws_after_abort",   32'(words_sent), 32'd1);
        check("pops_after_abort", 32'(pops - base_pops), 32'd2);

        // Counter wrap on the 8-bit instance: preload near the top so the
        // wrap costs four words instead of 65536.
        @(negedge clk);
        u_small.words_sent_q = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            s_dout  = 8'h30 + 8'(i);
            s_empty = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (s_r_en) begin ok = 1'b1; break; end
            end
            check("s_pop_seen", 32'(ok), 32'd1);
            @(posedge clk); #1 s_empty = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (!s_busy) begin ok = 1'b1; break; end
            end
            check("s_word_done", 32'(ok), 32'd1);
            exp16 = 16'hFFFE + 16'(i);
            check($sformatf("s_words_%0d", i), 32'(s_words), 32'(exp16));
            check($sformatf("s_pops_%0d", i),  32'(s_pops),  32'(i + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
